// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - framed asynchronous serial receiver with valid/ready output
//
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around mid-bit)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         serial input, asynchronous, idle high
//   data       received word, LSB is the first data bit on the line
//   valid      data/flags hold a word not yet consumed
//   ready      consumer accepts the word when valid && ready
//   parity_err parity mismatch on the held word
//   frame_err  a stop-bit sample was 0 on the held word
//   overrun    a frame was dropped before the held word was consumed

module uart_rx_framed #(
    parameter int BAUDRATE  = 1667,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              CW        = $clog2(BAUDRATE);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(BAUDRATE - 1);
    localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err_r;
    logic                   fe_r;
    logic                   rx_m;
    logic                   rx_s;
    logic                   sample_now;
    logic                   bit_val;
    logic                   wrap;
    logic                   done;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMPLE_AT = CW'((BAUDRATE >> 1) + 1);
    logic [1:0] hist;

    // hist[1] holds rx_s from two cycles ago, hist[0] from one cycle ago, so at
    // cnt == M2+1 the vote covers the samples at M2-1, M2 and M2+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample_now = (cnt == SAMPLE_AT);
    assign bit_val    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam logic [CW-1:0] SAMPLE_AT = CW'(BAUDRATE >> 1);

    assign sample_now = (cnt == SAMPLE_AT);
    assign bit_val    = rx_s;
`endif

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (sample_now && bit_val) begin
                    state_n = S_IDLE;
                end else if (wrap) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap && (bit_cnt == LAST_BIT)) begin
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the last stop sample rather than the wrap so a
                // back-to-back start bit is caught on time.
                if (sample_now && (stop_cnt == LAST_STOP)) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Bit timer: zero in IDLE and on every return to IDLE, so START always begins at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == S_IDLE) || (state_n == S_IDLE) || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_err_r <= 1'b0;
            fe_r      <= 1'b0;
        end else begin
            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (wrap) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state != S_STOP) begin
                stop_cnt <= 1'b0;
            end else if (wrap) begin
                stop_cnt <= 1'b1;
            end

            if ((state == S_DATA) && sample_now) begin
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            end

            if (state == S_START) begin
                par_err_r <= 1'b0;
            end else if ((state == S_PARITY) && sample_now) begin
                par_err_r <= ((^shreg) ^ bit_val) != (PARITY == 2);
            end

            if (state == S_START) begin
                fe_r <= 1'b0;
            end else if ((state == S_STOP) && sample_now && !bit_val) begin
                fe_r <= 1'b1;
            end
        end
    end

    // Output holding register; the stop sample taken this cycle is folded into frame_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!valid || ready) begin
                data       <= shreg;
                parity_err <= par_err_r;
                frame_err  <= fe_r | ~bit_val;
                valid      <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed

module tb_uart_rx_framed;

    logic       clk;
    logic       rst;
    logic [2:0] rx_v;
    logic [2:0] rdy;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [2:0] v;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] ov;
    logic [7:0] dout [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int start_cyc = 0;

    int         dcount   [3] = '{0, 0, 0};
    int         hicnt    [3] = '{0, 0, 0};
    int         rise_cyc [3] = '{0, 0, 0};
    logic [7:0] ldat     [3] = '{8'h0, 8'h0, 8'h0};
    logic [2:0] lpe  = 3'b0;
    logic [2:0] lfe  = 3'b0;
    logic [2:0] vprev = 3'b0;

    int base;
    int hbase;

    uart_rx_framed #(.BAUDRATE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .data(d0), .valid(v[0]), .ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
    );

    uart_rx_framed #(.BAUDRATE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7o1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .data(d1), .valid(v[1]), .ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
    );

    uart_rx_framed #(.BAUDRATE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .data(d2), .valid(v[2]), .ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2])
    );

    assign dout[0] = d0;
    assign dout[1] = {1'b0, d1};
    assign dout[2] = d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Delivery log, sampled 1 time unit after the negedge where inputs are driven.
    always begin
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (v[k] && !vprev[k]) rise_cyc[k] = cyc;
            if (v[k]) hicnt[k]++;
            if (v[k] && rdy[k]) begin
                dcount[k]++;
                ldat[k] = dout[k];
                lpe[k]  = pe[k];
                lfe[k]  = fe[k];
            end
            vprev[k] = v[k];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // bits[0] is the start bit; one bit period is 16 clocks, driven at negedges.
    task automatic send_bits(input int idx, input logic [15:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 16; c++) begin
                if (i == 0 && c == 0) start_cyc = cyc;
                rx_v[idx] = (glitch && i >= 1 && i <= 8 && c == 9) ? ~bits[i] : bits[i];
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int idx, input int n);
        rx_v[idx] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        rx_v = 3'b111;
        rdy  = 3'b111;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {29'b0, v}, 32'h0);
        check_eq("rst_data", {24'b0, d0}, 32'h0);
        check_eq("rst_flags", {23'b0, pe, fe, ov}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0xA5, ready high
        base  = dcount[0];
        hbase = hicnt[0];
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
        idle(0, 10);
        check_eq("a5_count", dcount[0] - base, 1);
        check_eq("a5_data", {24'b0, ldat[0]}, 32'hA5);
        check_eq("a5_flags", {30'b0, lpe[0], lfe[0]}, 32'h0);
        check_eq("a5_overrun", {31'b0, ov[0]}, 32'h0);
`ifdef UART_RX_MAJORITY_EN
        check_eq("a5_latency", rise_cyc[0] - start_cyc, 157);
`else
        check_eq("a5_latency", rise_cyc[0] - start_cyc, 156);
`endif
        check_eq("a5_valid_width", hicnt[0] - hbase, 1);
        check_eq("a5_valid_low", {31'b0, v[0]}, 32'h0);

        // 7O1 0x35: four ones, so the odd parity bit is 1
        send_bits(1, {6'b0, 1'b1, 1'b0, 7'h35, 1'b0}, 10, 1'b0);
        idle(1, 10);
        check_eq("par_bad_data", {24'b0, ldat[1]}, 32'h35);
        check_eq("par_bad_err", {31'b0, lpe[1]}, 32'h1);
        send_bits(1, {6'b0, 1'b1, 1'b1, 7'h35, 1'b0}, 10, 1'b0);
        idle(1, 10);
        check_eq("par_ok_data", {24'b0, ldat[1]}, 32'h35);
        check_eq("par_ok_err", {30'b0, lpe[1], lfe[1]}, 32'h0);

        // 8N2: second stop bit low, then back-to-back frame after one idle clock
        base = dcount[2];
        send_bits(2, {5'b0, 1'b0, 1'b1, 8'hC3, 1'b0}, 11, 1'b0);
        check_eq("fe_data", {24'b0, ldat[2]}, 32'hC3);
        check_eq("fe_flag", {31'b0, lfe[2]}, 32'h1);
        idle(2, 1);
        send_bits(2, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b0);
        idle(2, 30);
        check_eq("b2b_count", dcount[2] - base, 2);
        check_eq("b2b_data", {24'b0, ldat[2]}, 32'h3C);
        check_eq("b2b_flags", {30'b0, lpe[2], lfe[2]}, 32'h0);

        // Start-bit glitch rejection
        base = dcount[0];
        rx_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        idle(0, 30);
        check_eq("glitch_none", dcount[0] - base, 0);
        send_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 1'b0);
        idle(0, 10);
        check_eq("glitch_next_count", dcount[0] - base, 1);
        check_eq("glitch_next_data", {24'b0, ldat[0]}, 32'h81);
        check_eq("glitch_next_flags", {30'b0, lpe[0], lfe[0]}, 32'h0);

        // Overrun with ready low
        rdy[0] = 1'b0;
        send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, 1'b0);
        idle(0, 4);
        send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 1'b0);
        idle(0, 10);
        check_eq("ovr_data", {24'b0, d0}, 32'h11);
        check_eq("ovr_valid", {31'b0, v[0]}, 32'h1);
        check_eq("ovr_flag", {31'b0, ov[0]}, 32'h1);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        @(negedge clk);
        check_eq("ovr_consume", {30'b0, v[0], ov[0]}, 32'h0);
        rdy[0] = 1'b1;

        // Reset in the middle of data bit 4 of 0xFF
        base = dcount[0];
        send_bits(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 5, 1'b0);
        rx_v[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_out", {22'b0, d0, v[0], ov[0]}, 32'h0);
        rst = 1'b0;
        idle(0, 200);
        check_eq("midrst_none", dcount[0] - base, 0);
        send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);
        idle(0, 10);
        check_eq("post_rst_count", dcount[0] - base, 1);
        check_eq("post_rst_data", {24'b0, ldat[0]}, 32'h5A);
        check_eq("post_rst_flags", {30'b0, lpe[0], lfe[0]}, 32'h0);

`ifdef UART_RX_MAJORITY_EN
        send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 1'b1);
        idle(0, 10);
        check_eq("maj_data", {24'b0, ldat[0]}, 32'h5A);
        check_eq("maj_flags", {30'b0, lpe[0], lfe[0]}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
